// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer: vectored interrupt entry and interrupt command execution.
// Pushes PC and old level to the stack, then loads the vector; owns IE and current level.
module interrupt_sequencer #(
    parameter logic [11:0] VECTOR_BASE   = 12'o0100,
    parameter int          VECTOR_SHIFT  = 1,
    parameter int          SETTLE_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [11:0] i_next_interrupt,
    input  logic        i_insn_boundary,
    input  logic [11:0] i_pc_in,
    input  logic [11:0] i_sp_in,
    input  logic        i_cmd_valid,
    input  logic [2:0]  i_cmd_op,
    input  logic [11:0] i_cmd_data,
    output logic        o_cmd_ready,
    output logic        o_busy,
    output logic        o_mem_req,
    output logic [11:0] o_mem_addr,
    output logic [11:0] o_mem_wdata,
    input  logic        i_mem_ack,
    output logic        o_pc_load,
    output logic [11:0] o_pc_out,
    output logic        o_sp_load,
    output logic [11:0] o_sp_out,
    output logic        o_ic_dismiss,
    output logic        o_ic_create,
    output logic [11:0] o_ic_data,
    output logic        o_int_enable,
    output logic [11:0] o_cur_level
);
    typedef enum logic [1:0] {IDLE, PUSH_PC, PUSH_LVL, VECTOR} state_t;
    localparam logic [11:0] NONE = 12'o7777;

    state_t      r_state;
    logic        r_ie;
    logic [11:0] r_cur_level;
    logic [7:0]  r_settle;
    logic [11:0] r_num;
    logic [11:0] r_slvl;
    logic [11:0] r_ssp;
    logic        r_mem_req;
    logic [11:0] r_mem_addr;
    logic [11:0] r_mem_wdata;
    logic        r_pc_load;
    logic [11:0] r_pc_out;
    logic        r_sp_load;
    logic [11:0] r_sp_out;
    logic        r_ic_dismiss;
    logic        r_ic_create;
    logic [11:0] r_ic_data;
    logic        w_pend;
    logic [11:0] w_vec;

    assign w_pend = r_ie & (i_next_interrupt != NONE) & (i_next_interrupt < r_cur_level) & (r_settle == 8'd0);
    assign w_vec  = VECTOR_BASE + (r_num << VECTOR_SHIFT);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_ie         <= 1'b0;
            r_cur_level  <= NONE;
            r_settle     <= 8'd0;
            r_num        <= 12'd0;
            r_slvl       <= 12'd0;
            r_ssp        <= 12'd0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= 12'd0;
            r_mem_wdata  <= 12'd0;
            r_pc_load    <= 1'b0;
            r_pc_out     <= 12'd0;
            r_sp_load    <= 1'b0;
            r_sp_out     <= 12'd0;
            r_ic_dismiss <= 1'b0;
            r_ic_create  <= 1'b0;
            r_ic_data    <= 12'd0;
        end else begin
            r_pc_load    <= 1'b0;
            r_pc_out     <= 12'd0;
            r_sp_load    <= 1'b0;
            r_sp_out     <= 12'd0;
            r_ic_dismiss <= 1'b0;
            r_ic_create  <= 1'b0;
            r_ic_data    <= 12'd0;
            if (r_settle != 8'd0)
                r_settle <= r_settle - 8'd1;
            case (r_state)
                IDLE: begin
                    // commands win over entry in the same cycle
                    if (i_cmd_valid) begin
                        case (i_cmd_op)
                            3'd1: r_ie <= 1'b1;
                            3'd2: r_ie <= 1'b0;
                            3'd3: begin
                                r_cur_level <= i_cmd_data;
                                r_ie        <= 1'b1;
                            end
                            3'd4: begin
                                r_ic_dismiss <= 1'b1;
                                r_ic_data    <= i_cmd_data;
                                r_settle     <= 8'(SETTLE_CYCLES);
                            end
                            3'd5: begin
                                r_ic_create <= 1'b1;
                                r_ic_data   <= i_cmd_data;
                                r_settle    <= 8'(SETTLE_CYCLES);
                            end
                            3'd6: r_cur_level <= i_cmd_data;
                            default: ;
                        endcase
                    end else if (w_pend && i_insn_boundary) begin
                        r_num       <= i_next_interrupt;
                        r_slvl      <= r_cur_level;
                        r_ssp       <= i_sp_in;
                        r_mem_req   <= 1'b1;
                        r_mem_addr  <= i_sp_in - 12'd1;
                        r_mem_wdata <= i_pc_in;
                        r_state     <= PUSH_PC;
                    end
                end
                PUSH_PC: begin
                    if (i_mem_ack) begin
                        r_mem_addr  <= r_ssp - 12'd2;
                        r_mem_wdata <= r_slvl;
                        r_state     <= PUSH_LVL;
                    end
                end
                PUSH_LVL: begin
                    if (i_mem_ack) begin
                        r_mem_req   <= 1'b0;
                        r_mem_addr  <= 12'd0;
                        r_mem_wdata <= 12'd0;
                        r_pc_load   <= 1'b1;
                        r_pc_out    <= w_vec;
                        r_sp_load   <= 1'b1;
                        r_sp_out    <= r_ssp - 12'd2;
                        r_state     <= VECTOR;
                    end
                end
                default: begin
                    r_cur_level <= r_num;
                    r_ie        <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign o_cmd_ready  = (r_state == IDLE);
    assign o_busy       = (r_state != IDLE);
    assign o_mem_req    = r_mem_req;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_pc_load    = r_pc_load;
    assign o_pc_out     = r_pc_out;
    assign o_sp_load    = r_sp_load;
    assign o_sp_out     = r_sp_out;
    assign o_ic_dismiss = r_ic_dismiss;
    assign o_ic_create  = r_ic_create;
    assign o_ic_data    = r_ic_data;
    assign o_int_enable = r_ie;
    assign o_cur_level  = r_cur_level;
endmodule

// File: tb/tb_interrupt_sequencer.sv
// tb_interrupt_sequencer: directed scenarios plus random stimulus, checked every
// cycle against a phase-based behavioural model of interrupt entry and commands.
module tb_interrupt_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] next_int = 12'o7777;
    logic        bnd = 1'b0;
    logic [11:0] pc_in = 12'd0;
    logic [11:0] sp_in = 12'd0;
    logic        cmd_valid = 1'b0;
    logic [2:0]  cmd_op = 3'd0;
    logic [11:0] cmd_data = 12'd0;
    logic        mem_ack = 1'b0;
    logic        cmd_ready, busy, mem_req, pc_load, sp_load, ic_dismiss, ic_create, int_enable;
    logic [11:0] mem_addr, mem_wdata, pc_out, sp_out, ic_data, cur_level;

    int n_tests = 0;
    int n_fail = 0;
    int n_writes = 0;
    int n_pcl = 0;

    // model: phase 0 idle, 1 pushing PC, 2 pushing level, 3 vectoring
    int m_phase, m_ie, m_lvl, m_settle, m_num, m_spc, m_slvl, m_ssp, m_dis, m_cre, m_icd;
    bit m_pend;

    interrupt_sequencer dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_next_interrupt(next_int), .i_insn_boundary(bnd),
        .i_pc_in(pc_in), .i_sp_in(sp_in), .i_cmd_valid(cmd_valid), .i_cmd_op(cmd_op),
        .i_cmd_data(cmd_data), .o_cmd_ready(cmd_ready), .o_busy(busy), .o_mem_req(mem_req),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_ack(mem_ack),
        .o_pc_load(pc_load), .o_pc_out(pc_out), .o_sp_load(sp_load), .o_sp_out(sp_out),
        .o_ic_dismiss(ic_dismiss), .o_ic_create(ic_create), .o_ic_data(ic_data),
        .o_int_enable(int_enable), .o_cur_level(cur_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0o expected %0o at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_ie = 0; m_lvl = 4095; m_settle = 0;
            m_dis = 0; m_cre = 0; m_icd = 0;
        end else begin
            m_pend = m_ie != 0 && next_int != 4095 && int'(next_int) < m_lvl && m_settle == 0;
            m_dis = 0; m_cre = 0; m_icd = 0;
            if (m_settle > 0) m_settle--;
            if (m_phase == 0) begin
                if (cmd_valid) begin
                    if (cmd_op == 1) m_ie = 1;
                    if (cmd_op == 2) m_ie = 0;
                    if (cmd_op == 3) begin m_lvl = cmd_data; m_ie = 1; end
                    if (cmd_op == 6) m_lvl = cmd_data;
                    if (cmd_op == 4 || cmd_op == 5) begin
                        m_dis = (cmd_op == 4); m_cre = (cmd_op == 5);
                        m_icd = cmd_data; m_settle = 2;
                    end
                end else if (m_pend && bnd) begin
                    m_num = next_int; m_spc = pc_in; m_slvl = m_lvl; m_ssp = sp_in; m_phase = 1;
                end
            end else if (m_phase == 3) begin
                m_lvl = m_num; m_ie = 0; m_phase = 0;
            end else if (mem_ack) m_phase++;
        end
    end

    always @(posedge clk) begin
        if (rst_n && mem_req && mem_ack) n_writes++;
        if (rst_n && pc_load) n_pcl++;
    end

    always @(negedge clk) begin
        chk("busy", busy, m_phase != 0);
        chk("cmd_ready", cmd_ready, m_phase == 0);
        chk("mem_req", mem_req, m_phase == 1 || m_phase == 2);
        chk("mem_addr", mem_addr, m_phase == 1 ? (m_ssp + 4095) % 4096 : m_phase == 2 ? (m_ssp + 4094) % 4096 : 0);
        chk("mem_wdata", mem_wdata, m_phase == 1 ? m_spc : m_phase == 2 ? m_slvl : 0);
        chk("pc_load", pc_load, m_phase == 3);
        chk("pc_out", pc_out, m_phase == 3 ? (64 + m_num * 2) % 4096 : 0);
        chk("sp_load", sp_load, m_phase == 3);
        chk("sp_out", sp_out, m_phase == 3 ? (m_ssp + 4094) % 4096 : 0);
        chk("ic_dismiss", ic_dismiss, m_dis);
        chk("ic_create", ic_create, m_cre);
        chk("ic_data", ic_data, m_icd);
        chk("int_enable", int_enable, m_ie);
        chk("cur_level", cur_level, m_lvl);
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic cmd(input logic [2:0] op, input logic [11:0] d);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
        cyc();
        cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 12'd0;
    endtask

    task automatic wait_pc();
        bit ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            if (pc_load) ok = 1;
            else cyc();
        end
        chk("pc_load_seen", ok, 1);
    endtask

    initial begin
        logic [11:0] a0;
        int w0, p0;
        cyc(); cyc();
        chk("rst_level", cur_level, 12'o7777);
        chk("rst_ie", int_enable, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        cyc();
        // 1: basic entry
        cmd(3'd1, 12'd0);
        next_int = 12'd3; pc_in = 12'o1234; sp_in = 12'o2000; bnd = 1'b1; mem_ack = 1'b1;
        cyc();
        chk("t1_addr_pc", mem_addr, 12'o1777); chk("t1_data_pc", mem_wdata, 12'o1234);
        cyc();
        chk("t1_addr_lvl", mem_addr, 12'o1776); chk("t1_data_lvl", mem_wdata, 12'o7777);
        cyc();
        chk("t1_pc_load", pc_load, 1); chk("t1_pc_out", pc_out, 12'o0106); chk("t1_sp_out", sp_out, 12'o1776);
        cyc();
        chk("t1_level", cur_level, 3); chk("t1_ie", int_enable, 0);
        bnd = 1'b0; next_int = 12'o7777;
        // 2: lower priority blocked, then allowed
        cmd(3'd1, 12'd0); cmd(3'd6, 12'd2);
        next_int = 12'd5; bnd = 1'b1; w0 = n_writes;
        repeat (4) cyc();
        chk("t2_no_entry", n_writes - w0, 0);
        cmd(3'd6, 12'o7777);
        wait_pc();
        chk("t2_pc_out", pc_out, 12'o0112);
        cyc(); bnd = 1'b0; next_int = 12'o7777;
        // 3: stalled memory
        cmd(3'd1, 12'd0); cmd(3'd6, 12'o7777);
        mem_ack = 1'b0; next_int = 12'd3; bnd = 1'b1; w0 = n_writes;
        cyc();
        a0 = mem_addr;
        chk("t3_addr", a0, 12'o1777);
        repeat (4) begin
            cyc();
            chk("t3_req_hold", mem_req, 1); chk("t3_busy", busy, 1); chk("t3_addr_hold", mem_addr, a0);
        end
        mem_ack = 1'b1;
        wait_pc();
        chk("t3_writes", n_writes - w0, 2);
        cyc(); bnd = 1'b0; next_int = 12'o7777;
        // 4: dismiss settle window
        cmd(3'd1, 12'd0); cmd(3'd6, 12'o7777);
        next_int = 12'd4;
        cmd(3'd4, 12'd4);
        chk("t4_dismiss", ic_dismiss, 1); chk("t4_data", ic_data, 4);
        bnd = 1'b1;
        cyc();
        chk("t4_dismiss_off", ic_dismiss, 0); chk("t4_data_off", ic_data, 0); chk("t4_busy1", busy, 0);
        cyc(); chk("t4_busy2", busy, 0);
        cyc(); chk("t4_busy3", busy, 1);
        wait_pc();
        cyc(); bnd = 1'b0; next_int = 12'o7777;
        // 5: command beats pending entry
        cmd(3'd1, 12'd0); cmd(3'd6, 12'o7777);
        next_int = 12'd2; bnd = 1'b1;
        cmd(3'd5, 12'o7000);
        chk("t5_create", ic_create, 1); chk("t5_data", ic_data, 12'o7000);
        chk("t5_dismiss", ic_dismiss, 0); chk("t5_busy0", busy, 0);
        cyc(); chk("t5_busy1", busy, 0);
        cyc(); chk("t5_busy2", busy, 0);
        cyc(); chk("t5_busy3", busy, 1);
        wait_pc();
        cyc(); bnd = 1'b0; next_int = 12'o7777;
        // 6: wraparound and reset mid-entry
        cmd(3'd1, 12'd0); cmd(3'd6, 12'o7777);
        p0 = n_pcl; sp_in = 12'd0; next_int = 12'd1; bnd = 1'b1;
        cyc(); chk("t6_addr_pc", mem_addr, 12'o7777);
        cyc(); chk("t6_addr_lvl", mem_addr, 12'o7776);
        rst_n = 1'b0;
        #1;
        chk("t6_busy", busy, 0); chk("t6_ie", int_enable, 0); chk("t6_level", cur_level, 12'o7777);
        chk("t6_req", mem_req, 0);
        cyc(); cyc();
        chk("t6_no_pcl", n_pcl - p0, 0);
        rst_n = 1'b1; bnd = 1'b0; next_int = 12'o7777;
        cyc();
        // random phase
        for (int i = 0; i < 3000; i++) begin
            next_int  = ($urandom_range(0, 3) == 0) ? 12'o7777 : 12'($urandom_range(0, 15));
            bnd       = 1'($urandom_range(0, 1));
            pc_in     = 12'($urandom);
            sp_in     = 12'($urandom);
            mem_ack   = 1'($urandom_range(0, 1));
            cmd_valid = ($urandom_range(0, 3) == 0);
            cmd_op    = 3'($urandom_range(0, 7));
            cmd_data  = ($urandom_range(0, 3) == 0) ? 12'o7777 : 12'($urandom_range(0, 20));
            rst_n     = ($urandom_range(0, 199) != 0);
            cyc();
        end
        rst_n = 1'b1; cmd_valid = 1'b0;
        cyc(); cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
CPU-side counterpart of the interrupt controller. It consumes the controller's next_interrupt number and drives its dismiss/create/data_in command interface. At an instruction boundary it performs vectored interrupt entry: it stalls the core, pushes PC and the old priority level to the stack over a memory handshake, then loads PC with the vector. It also owns the global interrupt enable and the current priority level, and executes CPU interrupt commands (EI/DI/RETI/DISMISS/RAISE/SETLVL).

Parameters:
VECTOR_BASE, 12'o0100, base address of the vector table
VECTOR_SHIFT, 1, log2 of words per vector entry
SETTLE_CYCLES, 2, cycles interrupt entry is blocked after issuing DISMISS/RAISE to the controller

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
next_interrupt  input  12  from controller; 12'o7777 = none pending
insn_boundary  input  1  core is between instructions; entry allowed this cycle
pc_in  input  12  PC of the next instruction to execute
sp_in  input  12  current stack pointer (full-descending stack)
cmd_valid  input  1  core presents an interrupt command
cmd_op  input  3  0 NOP, 1 EI, 2 DI, 3 RETI, 4 DISMISS, 5 RAISE, 6 SETLVL, 7 reserved
cmd_data  input  12  command operand
cmd_ready  output  1  command accepted when cmd_valid & cmd_ready
busy  output  1  core must stall; high in every non-IDLE state
mem_req  output  1  stack write request
mem_addr  output  12  stack write address
mem_wdata  output  12  stack write data
mem_ack  input  1  write completes in a cycle where mem_req & mem_ack
pc_load  output  1  one-cycle strobe: core loads pc_out
pc_out  output  12  vector address
sp_load  output  1  one-cycle strobe: core loads sp_out
sp_out  output  12  new stack pointer
ic_dismiss  output  1  to controller dismiss
ic_create  output  1  to controller create
ic_data  output  12  to controller data_in
int_enable  output  1  global interrupt enable (IE)
cur_level  output  12  current priority level; 12'o7777 = not in a handler

Behaviour:
- Reset (async, rst low): state IDLE, IE=0, cur_level=12'o7777, settle=0, and every other output 0 (including ic_data).
- Pending condition: pend = IE & (next_interrupt != 12'o7777) & (next_interrupt < cur_level) & (settle == 0). Compare is unsigned, and a lower number means higher priority.
- cmd_ready = (state == IDLE). A command is accepted in IDLE when cmd_valid is high. In an accept cycle, interrupt entry is suppressed and commands take precedence.
- States IDLE -> PUSH_PC -> PUSH_LVL -> VECTOR -> IDLE.
- IDLE:
  - If pend & insn_boundary & !cmd_valid, latch num=next_interrupt, spc=pc_in, slvl=cur_level, ssp=sp_in, then go to PUSH_PC.
  - busy goes high in the next cycle.
- PUSH_PC:
  - mem_req=1, mem_addr=ssp-1, mem_wdata=spc.
  - Hold for as long as needed until mem_ack, then go to PUSH_LVL.
- PUSH_LVL:
  - mem_req=1, mem_addr=ssp-2, mem_wdata=slvl.
  - On mem_ack, go to VECTOR.
- VECTOR, single cycle:
  - pc_load=1, pc_out = (VECTOR_BASE + (num << VECTOR_SHIFT)) mod 2^12.
  - sp_load=1, sp_out = ssp-2.
  - At the clock edge: cur_level<=num, IE<=0, state<=IDLE.
- Address arithmetic is mod 4096: ssp=0 gives 12'o7777 and 12'o7776.
- mem_req is low outside PUSH_*. A mem_ack while mem_req is low is ignored.
- Commands (effects at the accepting clock edge):
  - EI: IE<=1.
  - DI: IE<=0.
  - RETI: cur_level<=cmd_data, IE<=1.
  - SETLVL: cur_level<=cmd_data.
  - DISMISS: ic_dismiss=1, ic_data=cmd_data for exactly the next cycle; settle<=SETTLE_CYCLES.
  - RAISE: same as DISMISS but drives ic_create.
  - NOP and op 7: no effect.
- ic_* outputs are registered. ic_dismiss and ic_create are never high together, and ic_data returns to 0 after the strobe.
- settle decrements by 1 per cycle while nonzero. This blocks entry until the controller reflects the dismiss or create.
- next_interrupt changing after the latch has no effect on an entry in progress. num is used.
- Reset mid-entry aborts immediately to reset values. No pc_load or sp_load is emitted.

Test Plan:
1. Reset, then EI. next_interrupt=3, cur_level=7777, pc_in=0o1234, sp_in=0o2000, boundary=1, mem_ack tied 1 -> writes 0o1234@0o1777 and 0o7777@0o1776. The following cycle gives pc_load with pc_out=0o0106, sp_out=0o1776, cur_level=3, IE=0.
2. IE=1, cur_level=2, next_interrupt=5 -> no entry. Then SETLVL 7777 -> entry with pc_out=0o0112.
3. mem_ack held low 4 cycles in PUSH_PC -> mem_req/addr/wdata stable, busy high throughout, and exactly 2 writes total.
4. DISMISS 4 accepted -> ic_dismiss=1, ic_data=4 for one cycle. With next_interrupt=4 still shown, no entry for 2 cycles.
5. cmd_valid RAISE 0o7000 together with pend & boundary -> command accepted, ic_create=1/ic_data=0o7000, and entry is deferred.
6. sp_in=0, mid-PUSH_LVL async reset -> addresses were 0o7777 then 0o7776. After reset: IDLE, IE=0, cur_level=7777, no pc_load.
